ov7670_capture: RTL and testbench
=================================

OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 SHALL have parameter RESOLUTION_WIDTH, default 640: pixels per line.
REQ-002 SHALL have parameter RESOLUTION_HEIGHT, default 480: lines per frame.
REQ-003 SHALL have port pclk, input, 1: camera pixel clock; sole clock; all sampling on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port vsync, input, 1: frame sync; high during the vertical sync pulse.
REQ-006 SHALL have port href, input, 1: high while line bytes are valid.
REQ-007 SHALL have port D, input, 8: camera data byte.
REQ-008 SHALL have port pixel, output, 16: assembled RGB565 pixel.
REQ-009 SHALL have port pixel_valid, output, 1: one-cycle strobe; pixel and wr_addr are valid.
REQ-010 SHALL have port wr_addr, output, clog2(W*H): frame-buffer pixel index of pixel.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse on a completed good frame.
REQ-012 SHALL have port frame_err, output, 1: sticky error, cleared at the next frame start.
REQ-013 SHALL have port frame_count, output, 16: count of good frames (see REQ-029).

Function
REQ-014 SHALL use states WAIT_SYNC, ARMED and ACTIVE; reset enters WAIT_SYNC.
REQ-015 WAIT_SYNC -> ARMED when vsync is sampled high.
REQ-016 ARMED -> ACTIVE when vsync is sampled low, i.e. vsync falling edge, the frame start; at entry the pixel index, byte phase and frame_err are cleared.
REQ-017 In ACTIVE, each href=1 edge samples D: phase 0 stores the high byte; phase 1 produces pixel={high,D} and pixel_valid=1 on the next cycle, so latency is 1 pclk. The phase then toggles.
REQ-018 wr_addr SHALL equal the running pixel index, 0..W*H-1, then increment after each pixel_valid.
REQ-019 href falling while phase=1 (odd byte count): the partial byte is discarded, phase resets to 0, frame_err=1.
REQ-020 Line length SHALL be checked at each href fall; a count other than W pixels sets frame_err=1.
REQ-021 Pixels beyond index W*H-1 SHALL be dropped with no pixel_valid and no address wrap, and frame_err=1.
REQ-022 Sampling vsync high in ACTIVE ends the frame and moves to ARMED. If exactly W*H pixels were captured and frame_err=0, frame_done pulses in the same cycle as the transition; otherwise there is no pulse and frame_err stays 1.
REQ-023 vsync and href both high in the same cycle: vsync takes priority and the byte is ignored.
REQ-024 pixel_valid and frame_done SHALL never be high in the same cycle.

Reset
REQ-025 Assertion of rst_n=0 at any time, including mid-frame, SHALL immediately force state to WAIT_SYNC.
REQ-026 Reset values SHALL be: pixel=0, pixel_valid=0, wr_addr=0, frame_done=0, frame_err=0, frame_count=0, phase=0.
REQ-027 After release, no pixel_valid SHALL occur before a complete vsync high->low sequence.

Configuration
REQ-028 Macro OV7670_CAPTURE_FRAME_COUNT_EN SHALL select the frame counter.
REQ-029 With OV7670_CAPTURE_FRAME_COUNT_EN defined, frame_count increments by 1 mod 2^16 on each frame_done. Without it, frame_count is constant 0 and the counter is not synthesized; all other behaviour is identical.

Verification
REQ-030 Test W=4, H=2, a clean frame of 16 bytes 0x01..0x10 -> pixels 0x0102,0x0304,...,0x0F10 at wr_addr 0..7, then one frame_done, frame_err=0.
REQ-031 Test W=4, H=2, line 0 with 7 bytes -> 3 pixels, frame_err=1, and no frame_done at the next vsync.
REQ-032 Test W=4, H=2, 3 lines of data -> only 8 pixel_valid strobes, wr_addr ends at 7, frame_err=1.
REQ-033 Test: vsync asserted after 5 pixels -> no frame_done, state ARMED; the next clean frame produces a good frame_done.
REQ-034 Test: rst_n pulsed low mid-line -> all outputs 0 at once, and no pixel_valid until after vsync high->low.
REQ-035 Test with OV7670_CAPTURE_FRAME_COUNT_EN: 3 clean frames -> frame_count=3; without the macro, frame_count=0 throughout.

Source files
------------

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture: assembles byte pairs into pixels with frame-buffer
// addresses and checks frame geometry.
// Ports:
//   pclk, rst_n      - camera pixel clock, async active-low reset
//   vsync, href, D   - camera sync and data inputs
//   pixel, pixel_valid, wr_addr - assembled pixel strobe and its index
//   frame_done, frame_err       - good-frame pulse, sticky error flag
//   frame_count                 - good-frame counter
// Define OV7670_CAPTURE_FRAME_COUNT_EN to build the frame counter;
// when the macro is undefined, frame_count is tied to 0.
module ov7670_capture #(
  parameter int RESOLUTION_WIDTH  = 640,
  parameter int RESOLUTION_HEIGHT = 480,
  localparam int NPIX = RESOLUTION_WIDTH * RESOLUTION_HEIGHT,
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    D,
  output logic [15:0]   pixel,
  output logic          pixel_valid,
  output logic [AW-1:0] wr_addr,
  output logic          frame_done,
  output logic          frame_err,
  output logic [15:0]   frame_count
);

  // Line counter saturates at W+1 so over-long lines still miscompare.
  localparam int LW = $clog2(RESOLUTION_WIDTH + 2);
  localparam logic [AW:0]   NPIX_V = (AW+1)'(NPIX);
  localparam logic [LW-1:0] W_V    = LW'(RESOLUTION_WIDTH);
  localparam logic [LW-1:0] LMAX_V = LW'(RESOLUTION_WIDTH + 1);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    ARMED,
    ACTIVE
  } state_e;

  state_e        state_q, state_d;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic [AW:0]   pix_q, pix_d;
  logic [LW-1:0] line_q, line_d;
  logic          err_q, err_d;
  logic [15:0]   pixel_q, pixel_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          pvld_q, pvld_d;
  logic          done_q, done_d;
  logic          href_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_SYNC;
      phase_q <= 1'b0;
      hi_q    <= '0;
      pix_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
      pixel_q <= '0;
      addr_q  <= '0;
      pvld_q  <= 1'b0;
      done_q  <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      err_q   <= err_d;
      pixel_q <= pixel_d;
      addr_q  <= addr_d;
      pvld_q  <= pvld_d;
      done_q  <= done_d;
      href_q  <= href;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    pix_d   = pix_q;
    line_d  = line_q;
    err_d   = err_q;
    pixel_d = pixel_q;
    addr_d  = addr_q;
    pvld_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      WAIT_SYNC: begin
        if (vsync) state_d = ARMED;
      end
      ARMED: begin
        if (!vsync) begin
          state_d = ACTIVE;
          pix_d   = '0;
          phase_d = 1'b0;
          line_d  = '0;
          err_d   = 1'b0;
        end
      end
      ACTIVE: begin
        // vsync wins over a simultaneous href byte.
        if (vsync) begin
          state_d = ARMED;
          if (pix_q == NPIX_V && !err_q) done_d = 1'b1;
          else err_d = 1'b1;
        end else if (href) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = D;
          end else begin
            if (line_q != LMAX_V) line_d = line_q + 1'b1;
            if (pix_q < NPIX_V) begin
              pvld_d  = 1'b1;
              pixel_d = {hi_q, D};
              addr_d  = pix_q[AW-1:0];
              pix_d   = pix_q + 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (href_q) begin
          // End of line: odd byte count or wrong width is an error.
          phase_d = 1'b0;
          line_d  = '0;
          if (phase_q || line_q != W_V) err_d = 1'b1;
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  assign pixel       = pixel_q;
  assign pixel_valid = pvld_q;
  assign wr_addr     = addr_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;

`ifdef OV7670_CAPTURE_FRAME_COUNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) fcnt_q <= '0;
    else if (done_d) fcnt_q <= fcnt_q + 16'd1;
  end

  assign frame_count = fcnt_q;
`else
  assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture at 4x2 resolution.
// Expected pixels/frame_done events are queued; a monitor pops on output.
module tb_ov7670_capture;

  localparam int W = 4;
  localparam int H = 2;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  D = 8'h00;
  logic [15:0] pixel;
  logic        pixel_valid;
  logic [2:0]  wr_addr;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_count;

  ov7670_capture #(
    .RESOLUTION_WIDTH (W),
    .RESOLUTION_HEIGHT(H)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .href       (href),
    .D          (D),
    .pixel      (pixel),
    .pixel_valid(pixel_valid),
    .wr_addr    (wr_addr),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_count(frame_count)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit          is_done;
    logic [15:0] pix;
    logic [2:0]  addr;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pix(input logic [15:0] p, input logic [2:0] a);
    exp_t e;
    e.is_done = 1'b0;
    e.pix     = p;
    e.addr    = a;
    e.cnt     = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
`ifdef OV7670_CAPTURE_FRAME_COUNT_EN
    exp_cnt = exp_cnt + 16'd1;
`endif
    e.is_done = 1'b1;
    e.pix     = '0;
    e.addr    = '0;
    e.cnt     = exp_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: every output event must match the head of the queue.
  always @(negedge pclk) begin
    exp_t e;
    if (rst_n && (pixel_valid || frame_done)) begin
      chk("valid_done_exclusive", {31'd0, pixel_valid & frame_done}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: pixel_valid=%0b frame_done=%0b pixel=%0h addr=%0d",
                 pixel_valid, frame_done, pixel, wr_addr);
      end else begin
        e = exp_q.pop_front();
        if (e.is_done) begin
          chk("done_kind", {31'd0, frame_done}, 32'd1);
          chk("done_count", {16'd0, frame_count}, {16'd0, e.cnt});
          chk("done_err", {31'd0, frame_err}, 32'd0);
        end else begin
          chk("pix_kind", {31'd0, pixel_valid}, 32'd1);
          chk("pix_data", {16'd0, pixel}, {16'd0, e.pix});
          chk("pix_addr", {29'd0, wr_addr}, {29'd0, e.addr});
        end
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    href = 1'b1;
    D    = b;
    tick();
  endtask

  task automatic gap();
    href = 1'b0;
    D    = 8'h00;
    tick();
    tick();
  endtask

  task automatic send_line(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) send_byte(base + 8'(k));
    gap();
  endtask

  // Ends the current frame and starts the next one.
  task automatic end_frame(input bit good, input string tag);
    if (good) push_done();
    vsync = 1'b1;
    tick();
    chk({tag, "_err_at_end"}, {31'd0, frame_err}, good ? 32'd0 : 32'd1);
    tick();
    tick();
    vsync = 1'b0;
    tick();
    chk({tag, "_err_cleared"}, {31'd0, frame_err}, 32'd0);
  endtask

  task automatic clean_frame(input logic [7:0] base, input string tag);
    for (int i = 0; i < 8; i++)
      push_pix({base + 8'(2*i+1), base + 8'(2*i+2)}, 3'(i));
    send_line(base + 8'd1, 8);
    send_line(base + 8'd9, 8);
    chk({tag, "_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_last_addr"}, {29'd0, wr_addr}, 32'd7);
    end_frame(1'b1, tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pixel"}, {16'd0, pixel}, 32'd0);
    chk({tag, "_pixel_valid"}, {31'd0, pixel_valid}, 32'd0);
    chk({tag, "_wr_addr"}, {29'd0, wr_addr}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_frame_count"}, {16'd0, frame_count}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Bytes before any vsync must produce nothing.
    send_line(8'hE1, 8);

    // First frame start from WAIT_SYNC.
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();

    // Clean frame: 0x0102..0x0F10 at 0..7, then frame_done.
    clean_frame(8'h00, "clean1");

    // Line 0 with 7 bytes: 3 pixels, error, no frame_done.
    push_pix(16'h2122, 3'd0);
    push_pix(16'h2324, 3'd1);
    push_pix(16'h2526, 3'd2);
    send_line(8'h21, 7);
    chk("odd_line_err", {31'd0, frame_err}, 32'd1);
    end_frame(1'b0, "odd");

    // Three lines: only 8 pixels, last address 7, error.
    for (int i = 0; i < 8; i++)
      push_pix({8'h41 + 8'(2*i), 8'h42 + 8'(2*i)}, 3'(i));
    send_line(8'h41, 8);
    send_line(8'h49, 8);
    chk("three_err_mid", {31'd0, frame_err}, 32'd0);
    send_line(8'h51, 8);
    chk("three_err", {31'd0, frame_err}, 32'd1);
    chk("three_last_addr", {29'd0, wr_addr}, 32'd7);
    end_frame(1'b0, "three");

    // vsync after 5 pixels, with a byte coinciding with vsync high.
    for (int i = 0; i < 4; i++)
      push_pix({8'h61 + 8'(2*i), 8'h62 + 8'(2*i)}, 3'(i));
    push_pix(16'h696A, 3'd4);
    send_line(8'h61, 8);
    send_byte(8'h69);
    send_byte(8'h6A);
    send_byte(8'h6B);
    vsync = 1'b1;
    href  = 1'b1;
    D     = 8'h6C;
    tick();
    chk("short_err", {31'd0, frame_err}, 32'd1);
    href = 1'b0;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    chk("short_err_cleared", {31'd0, frame_err}, 32'd0);
    clean_frame(8'h70, "clean2");

    // Reset pulse mid-line.
    push_pix(16'h8182, 3'd0);
    send_byte(8'h81);
    send_byte(8'h82);
    send_byte(8'h83);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    chk("midreset_queue", exp_q.size(), 32'd0);
    exp_cnt = 16'd0;
    href = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // No output until a full vsync high->low sequence.
    send_line(8'hC1, 8);
    vsync = 1'b1;
    tick();
    send_line(8'hD1, 8);
    vsync = 1'b0;
    tick();

    // Three clean frames for the counter.
    clean_frame(8'h90, "cnt1");
    clean_frame(8'hA0, "cnt2");
    clean_frame(8'hB0, "cnt3");
`ifdef OV7670_CAPTURE_FRAME_COUNT_EN
    chk("frame_count_final", {16'd0, frame_count}, 32'd3);
`else
    chk("frame_count_final", {16'd0, frame_count}, 32'd0);
`endif

    tick();
    tick();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
